// File: rtl/wb_serial_tl_bridge.sv
// Wishbone classic slave that frames each bus cycle as HDR/ADR[/DAT] words over a
// narrow valid/ready serial link and reassembles the read response from the return link.
module wb_serial_tl_bridge #(
    parameter int SERIAL_W = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                serial_tl_bits_out_valid,
    input  logic                serial_tl_bits_out_ready,
    output logic [SERIAL_W-1:0] serial_tl_bits_out_bits,
    input  logic                serial_tl_bits_in_valid,
    output logic                serial_tl_bits_in_ready,
    input  logic [SERIAL_W-1:0] serial_tl_bits_in_bits,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int          BEATS        = 32 / SERIAL_W;
    localparam logic [5:0]  LAST_BEAT    = 6'(BEATS - 1);
    // Timer value seen in the final permitted RECV cycle.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_ADR,
        SEND_DAT,
        RECV,
        ACK
    } state_t;

    state_t state, state_next;

    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] tx_word;
    logic [31:0] rx_word;
    logic [31:0] result;
    logic [5:0]  beat_cnt;
    logic [31:0] timer;

    logic sending;
    logic receiving;
    logic start;
    logic out_fire;
    logic in_fire;
    logic last_beat;
    logic timed_out;

    logic [SERIAL_W+31:0] tx_cat;
    logic [SERIAL_W+31:0] rx_cat;
    logic [31:0]          tx_shift;
    logic [31:0]          rx_shift;

    // The ack guard stops the still-asserted strobe of the cycle just acked from being re-captured.
    assign start     = (state == IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign sending   = (state == SEND_HDR) || (state == SEND_ADR) || (state == SEND_DAT);
    assign receiving = (state == RECV);
    assign out_fire  = sending && serial_tl_bits_out_ready;
    assign in_fire   = receiving && serial_tl_bits_in_valid;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign timed_out = (TIMEOUT != 0) && receiving && (timer == TIMEOUT_LAST);

    // Outbound words go LSB first; inbound beats enter at the top and settle LSB first.
    assign tx_cat   = {{SERIAL_W{1'b0}}, tx_word};
    assign tx_shift = tx_cat[SERIAL_W+31:SERIAL_W];
    assign rx_cat   = {serial_tl_bits_in_bits, rx_word};
    assign rx_shift = rx_cat[SERIAL_W+31:SERIAL_W];

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and link-side outputs.
    always_comb begin
        state_next               = state;
        serial_tl_bits_out_valid = sending;
        serial_tl_bits_out_bits  = sending ? tx_word[SERIAL_W-1:0] : '0;
        serial_tl_bits_in_ready  = receiving;
        busy_o                   = (state != IDLE);
        case (state)
            IDLE:     if (start) state_next = SEND_HDR;
            SEND_HDR: if (out_fire && last_beat) state_next = SEND_ADR;
            SEND_ADR: if (out_fire && last_beat) state_next = we_q ? SEND_DAT : RECV;
            SEND_DAT: if (out_fire && last_beat) state_next = ACK;
            RECV:     if (timed_out || (in_fire && last_beat)) state_next = ACK;
            ACK:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Beat counter and RECV cycle timer; a timeout abandons any partial word.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            beat_cnt <= '0;
            timer    <= '0;
        end else begin
            if (timed_out)                beat_cnt <= '0;
            else if (out_fire || in_fire) beat_cnt <= last_beat ? 6'd0 : beat_cnt + 6'd1;
            timer <= receiving ? timer + 32'd1 : 32'd0;
        end
    end

    // Request capture and outbound word sequencing.
    always_ff @(posedge wb_clk_i) begin
        if (start) begin
            we_q    <= wbs_we_i;
            sel_q   <= wbs_sel_i;
            adr_q   <= wbs_adr_i;
            dat_q   <= wbs_dat_i;
            tx_word <= {wbs_we_i, wbs_sel_i, 27'd0};
        end else if (out_fire) begin
            if (last_beat) tx_word <= (state == SEND_HDR) ? adr_q : dat_q;
            else           tx_word <= tx_shift;
        end
    end

    // Response reassembly; the timeout pattern replaces a partial word.
    always_ff @(posedge wb_clk_i) begin
        if (!receiving)   rx_word <= '0;
        else if (in_fire) rx_word <= rx_shift;
        if (timed_out)                   result <= 32'hFFFF_FFFF;
        else if (in_fire && last_beat)   result <= rx_shift;
    end

    // Wishbone ack/data and sticky timeout flag; an abandoned master gets neither ack nor data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            timeout_o <= 1'b0;
        end else begin
            wbs_ack_o <= (state == ACK) && wbs_cyc_i && wbs_stb_i;
            if ((state == ACK) && wbs_cyc_i && wbs_stb_i && !we_q) wbs_dat_o <= result;
            if (timed_out) timeout_o <= 1'b1;
        end
    end

endmodule
